// File: rtl/multiplexer_pkg.sv
// Shared constants, types and helpers for the multiplexer leaf.
// Imported by mux_core and multiplexer.
package multiplexer_pkg;

    localparam int MUX_MAX_INPUTS = 16;

    // Default data element: a single bit.
    typedef logic [0:0] mux_bit_t;

    // Select width for n inputs, never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multiplexer_mux_core.sv
// Pure combinational select/enable/range-check core of the multiplexer.
// The o_sel_oor flag exists only when MULTIPLEXER_SEL_ERR_EN is defined.
module mux_core
    import multiplexer_pkg::*;
#(
    parameter  int N_INPUTS = 4,
    parameter  int DATA_W   = $bits(mux_bit_t),
    localparam int SEL_W    = sel_width(N_INPUTS)
) (
    input  logic [N_INPUTS*DATA_W-1:0] i_data,
    input  logic [SEL_W-1:0]           i_sel,
    input  logic                       i_en,
    output logic [DATA_W-1:0]          o_data
`ifdef MULTIPLEXER_SEL_ERR_EN
    ,
    output logic                       o_sel_oor
`endif
);

    logic              w_oor;
    logic [DATA_W-1:0] w_sel;

    // Selects past the last input only exist when N_INPUTS leaves codes unused.
    if (N_INPUTS == (1 << SEL_W)) begin : g_pow2
        assign w_oor = 1'b0;
    end else begin : g_npow2
        assign w_oor = (i_sel >= SEL_W'(N_INPUTS));
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_sel = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (i_sel == SEL_W'(k)) begin
                w_sel = i_data[k*DATA_W +: DATA_W];
            end
        end
        // Enable is tested first so an unknown select cannot leak through when disabled.
        o_data = (i_en && !w_oor) ? w_sel : '0;
    end

`ifdef MULTIPLEXER_SEL_ERR_EN
    assign o_sel_oor = w_oor;
`endif

endmodule

// File: rtl/multiplexer.sv
// N-input DATA_W-bit multiplexer: combinational y plus registered y_q/y_vld.
// Defining MULTIPLEXER_SEL_ERR_EN adds a registered out-of-range select flag, sel_err.
module multiplexer
    import multiplexer_pkg::*;
#(
    parameter  int N_INPUTS = 4,
    parameter  int DATA_W   = $bits(mux_bit_t),
    localparam int SEL_W    = sel_width(N_INPUTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_INPUTS*DATA_W-1:0] i,
    input  logic [SEL_W-1:0]           s,
    input  logic                       e,
    output logic [DATA_W-1:0]          y,
    output logic [DATA_W-1:0]          y_q,
    output logic                       y_vld
`ifdef MULTIPLEXER_SEL_ERR_EN
    ,
    output logic                       sel_err
`endif
);

    logic [DATA_W-1:0] w_y;
    logic [DATA_W-1:0] r_y_q;
    logic              r_y_vld;

`ifdef MULTIPLEXER_SEL_ERR_EN
    logic w_sel_oor;
    logic r_sel_err;
`endif

    mux_core #(
        .N_INPUTS (N_INPUTS),
        .DATA_W   (DATA_W)
    ) u_core (
        .i_data    (i),
        .i_sel     (s),
        .i_en      (e),
        .o_data    (w_y)
`ifdef MULTIPLEXER_SEL_ERR_EN
        ,
        .o_sel_oor (w_sel_oor)
`endif
    );

    // Reset wins over capture on the same edge.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_y_q   <= '0;
            r_y_vld <= 1'b0;
        end else begin
            r_y_q   <= w_y;
            r_y_vld <= e;
        end
    end

`ifdef MULTIPLEXER_SEL_ERR_EN
    // w_sel_oor is constant 0 for power-of-two N_INPUTS, so the flag stays 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= e && w_sel_oor;
        end
    end

    assign sel_err = r_sel_err;
`endif

    assign y     = w_y;
    assign y_q   = r_y_q;
    assign y_vld = r_y_vld;

endmodule

// File: tb/tb_multiplexer.sv
// Self-checking bench for multiplexer: a default 4:1x1 instance and a 3:1x8 instance.
// Covers table vectors, reset sequences and a randomized comparison against a reference model.
module tb_multiplexer;
    import multiplexer_pkg::*;

    logic        clk;
    logic        rst_n;

    logic [3:0]  i4;
    logic [1:0]  s4;
    logic        e4;
    logic        y4, yq4, vld4;

    logic [23:0] i3;
    logic [1:0]  s3;
    logic        e3;
    logic [7:0]  y3, yq3;
    logic        vld3;

`ifdef MULTIPLEXER_SEL_ERR_EN
    logic        err4, err3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    multiplexer dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i4),
        .s       (s4),
        .e       (e4),
        .y       (y4),
        .y_q     (yq4),
        .y_vld   (vld4)
`ifdef MULTIPLEXER_SEL_ERR_EN
        ,
        .sel_err (err4)
`endif
    );

    multiplexer #(.N_INPUTS(3), .DATA_W(8)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i       (i3),
        .s       (s3),
        .e       (e3),
        .y       (y3),
        .y_q     (yq3),
        .y_vld   (vld3)
`ifdef MULTIPLEXER_SEL_ERR_EN
        ,
        .sel_err (err3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour: pick slice sel of width w when enabled and in range, else zero.
    function automatic logic [7:0] ref_mux(input int n, input int w, input logic [31:0] iv,
                                           input int sel, input logic en);
        logic [31:0] mask;
        if (!en || sel >= n) return 8'h00;
        mask = (32'd1 << w) - 32'd1;
        return 8'((iv >> (sel * w)) & mask);
    endfunction

    typedef struct {
        bit          use3;
        logic [23:0] iv;
        logic [1:0]  sv;
        logic        ev;
        logic [7:0]  y_exp;
        logic        err_exp;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] m4, m3;
    logic       exp_err3;

    initial begin
        // 4:1 x1, i = 0101: disabled, then select sweep; then i = 1010 sweep.
        for (int k = 0; k < 4; k++) vecs.push_back('{0, 24'h5, 2'(k), 1'b0, 8'h00, 1'b0});
        vecs.push_back('{0, 24'h5, 2'd0, 1'b1, 8'h01, 1'b0});
        vecs.push_back('{0, 24'h5, 2'd1, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{0, 24'h5, 2'd2, 1'b1, 8'h01, 1'b0});
        vecs.push_back('{0, 24'h5, 2'd3, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{0, 24'hA, 2'd0, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{0, 24'hA, 2'd1, 1'b1, 8'h01, 1'b0});
        vecs.push_back('{0, 24'hA, 2'd2, 1'b1, 8'h00, 1'b0});
        vecs.push_back('{0, 24'hA, 2'd3, 1'b1, 8'h01, 1'b0});
        // 3:1 x8, i = {C3,5A,11}: sweep including out-of-range, then disabled.
        vecs.push_back('{1, 24'hC35A11, 2'd0, 1'b1, 8'h11, 1'b0});
        vecs.push_back('{1, 24'hC35A11, 2'd1, 1'b1, 8'h5A, 1'b0});
        vecs.push_back('{1, 24'hC35A11, 2'd2, 1'b1, 8'hC3, 1'b0});
        vecs.push_back('{1, 24'hC35A11, 2'd3, 1'b1, 8'h00, 1'b1});
        vecs.push_back('{1, 24'hC35A11, 2'd1, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1, 24'hC35A11, 2'd3, 1'b0, 8'h00, 1'b0});

        rst_n = 1'b0;
        i4 = '0; s4 = '0; e4 = 1'b0;
        i3 = '0; s3 = '0; e3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset yq4", 32'(yq4), 32'h0);
        check("reset vld4", 32'(vld4), 32'h0);
        check("reset yq3", 32'(yq3), 32'h0);
        check("reset vld3", 32'(vld3), 32'h0);
`ifdef MULTIPLEXER_SEL_ERR_EN
        check("reset err3", 32'(err3), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors.
        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            if (vecs[k].use3) begin
                i3 = vecs[k].iv; s3 = vecs[k].sv; e3 = vecs[k].ev; e4 = 1'b0;
            end else begin
                i4 = vecs[k].iv[3:0]; s4 = vecs[k].sv; e4 = vecs[k].ev; e3 = 1'b0;
            end
            #1;
            if (vecs[k].use3) check($sformatf("tbl%0d y3", k), 32'(y3), 32'(vecs[k].y_exp));
            else              check($sformatf("tbl%0d y4", k), 32'(y4), 32'(vecs[k].y_exp));
            @(posedge clk);
            #1;
            if (vecs[k].use3) begin
                check($sformatf("tbl%0d yq3", k), 32'(yq3), 32'(vecs[k].y_exp));
                check($sformatf("tbl%0d vld3", k), 32'(vld3), 32'(vecs[k].ev));
`ifdef MULTIPLEXER_SEL_ERR_EN
                check($sformatf("tbl%0d err3", k), 32'(err3), 32'(vecs[k].err_exp));
`endif
            end else begin
                check($sformatf("tbl%0d yq4", k), 32'(yq4), 32'(vecs[k].y_exp));
                check($sformatf("tbl%0d vld4", k), 32'(vld4), 32'(vecs[k].ev));
`ifdef MULTIPLEXER_SEL_ERR_EN
                check($sformatf("tbl%0d err4", k), 32'(err4), 32'h0);
`endif
            end
        end

        // Synchronous reset asserted between edges, with e=1 and y=1 on the reset edge.
        @(negedge clk);
        i4 = 4'b0101; s4 = 2'd0; e4 = 1'b1; e3 = 1'b0;
        @(posedge clk);
        #1;
        check("pre-rst yq4", 32'(yq4), 32'h1);
        check("pre-rst vld4", 32'(vld4), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst hold yq4", 32'(yq4), 32'h1);
        check("rst hold vld4", 32'(vld4), 32'h1);
        check("rst y4 live", 32'(y4), 32'h1);
        s4 = 2'd1;
        #1;
        check("rst y4 follows s", 32'(y4), 32'h0);
        s4 = 2'd2;
        @(posedge clk);
        #1;
        check("rst edge yq4", 32'(yq4), 32'h0);
        check("rst edge vld4", 32'(vld4), 32'h0);
        check("rst edge y4", 32'(y4), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        s4 = 2'd0;
        @(posedge clk);
        #1;
        check("post-rst yq4", 32'(yq4), 32'h1);
        check("post-rst vld4", 32'(vld4), 32'h1);

        // Disabled mux with unknown select still drives zero.
        @(negedge clk);
        e4 = 1'b0; s4 = 2'bxx; i4 = 4'hF;
        e3 = 1'b0; s3 = 2'bxx; i3 = 24'hFFFFFF;
        #1;
        check("x sel y4", 32'(y4), 32'h0);
        check("x sel y3", 32'(y3), 32'h0);
        @(posedge clk);
        #1;
        check("x sel yq4", 32'(yq4), 32'h0);
        check("x sel vld4", 32'(vld4), 32'h0);

        // Randomized comparison against the reference model, reset included.
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 9) != 0);
            i4 = 4'($urandom);  s4 = 2'($urandom); e4 = 1'($urandom);
            i3 = 24'($urandom); s3 = 2'($urandom); e3 = 1'($urandom);
            #1;
            m4 = ref_mux(4, 1, 32'(i4), int'(s4), e4);
            m3 = ref_mux(3, 8, 32'(i3), int'(s3), e3);
            exp_err3 = rst_n && e3 && (int'(s3) >= 3);
            check($sformatf("rnd%0d y4", c), 32'(y4), 32'(m4));
            check($sformatf("rnd%0d y3", c), 32'(y3), 32'(m3));
            @(posedge clk);
            #1;
            check($sformatf("rnd%0d yq4", c), 32'(yq4), rst_n ? 32'(m4) : 32'h0);
            check($sformatf("rnd%0d vld4", c), 32'(vld4), 32'(rst_n && e4));
            check($sformatf("rnd%0d yq3", c), 32'(yq3), rst_n ? 32'(m3) : 32'h0);
            check($sformatf("rnd%0d vld3", c), 32'(vld3), 32'(rst_n && e3));
`ifdef MULTIPLEXER_SEL_ERR_EN
            check($sformatf("rnd%0d err3", c), 32'(err3), 32'(exp_err3));
            check($sformatf("rnd%0d err4", c), 32'(err4), 32'h0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
